// File: rtl/display_mode_scheduler.sv
// Rotates the seven-segment display through four fitness metrics with a timed dwell,
// a blanking gap between metrics, and hold / next / enable-mask control.
module display_mode_scheduler #(
    parameter int TICK_DIV     = 100000000,
    parameter int DWELL_SEC    = 2,
    parameter int BLANK_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [13:0] totalSteps,
    input  logic [13:0] distanceCovered,
    input  logic [13:0] thirtyTwoStepsPerSecond,
    input  logic [13:0] sixtyFourStepsPerSecond,
    input  logic [3:0]  modeMask,
    input  logic        hold,
    input  logic        next,
    output logic [1:0]  modeSel,
    output logic [13:0] dispValue,
    output logic [3:0]  dispDp,
    output logic        dispBlank,
    output logic        modeChange
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (DWELL_SEC > 1) ? $clog2(DWELL_SEC) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [0:0] SHOW  = 1'b0;
    localparam logic [0:0] BLANK = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] prescaler;
    logic [SW-1:0] sec_cnt;
    logic [BW-1:0] blank_cnt;
    logic          tick;
    logic          expire;
    logic          leave_show;
    logic          leave_blank;
    logic [13:0]   raw;
    logic [13:0]   sat;
    logic [1:0]    next_sel;

    assign tick        = (prescaler == PW'(TICK_DIV - 1));
    assign expire      = tick && !hold && (sec_cnt == SW'(DWELL_SEC - 1));
    // A disabled current metric only forces a change when something else is enabled.
    assign leave_show  = expire || next || ((modeMask != 4'd0) && !modeMask[modeSel]);
    assign leave_blank = (blank_cnt == BW'(BLANK_CYCLES - 1));

    always_comb begin
        raw = totalSteps;
        case (modeSel)
            2'd0:    raw = totalSteps;
            2'd1:    raw = distanceCovered;
            2'd2:    raw = thirtyTwoStepsPerSecond;
            default: raw = sixtyFourStepsPerSecond;
        endcase
        sat = (raw > 14'd9999) ? 14'd9999 : raw;
    end

    // Descending scan so the nearest enabled successor wins; falls back to modeSel itself.
    always_comb begin
        next_sel = 2'd0;
        if (modeMask != 4'd0) begin
            next_sel = modeSel;
            for (int k = 3; k >= 1; k--) begin
                if (modeMask[modeSel + 2'(k)]) next_sel = modeSel + 2'(k);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= SHOW;
            modeSel    <= 2'd0;
            prescaler  <= '0;
            sec_cnt    <= '0;
            blank_cnt  <= '0;
            dispValue  <= 14'd0;
            modeChange <= 1'b0;
        end else begin
            modeChange <= 1'b0;
            case (state)
                SHOW: begin
                    dispValue <= sat;
                    if (leave_show) begin
                        state     <= BLANK;
                        prescaler <= '0;
                        sec_cnt   <= '0;
                        blank_cnt <= '0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + 1'b1;
                        if (tick && !hold) sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                default: begin
                    if (leave_blank) begin
                        state      <= SHOW;
                        modeSel    <= next_sel;
                        modeChange <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign dispBlank = (state == BLANK);
    assign dispDp    = (modeSel == 2'd1) ? 4'b0010 : 4'b0000;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Bench for display_mode_scheduler: table-driven rotation/mask periods plus hand-written
// hold, next, mask-clear and reset-mid-blank sequences; a modeChange scoreboard runs alongside.
module tb_display_mode_scheduler;
    localparam int TD = 4, DW = 2, BC = 3, NV = 11;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [13:0] totalSteps, distanceCovered, thirtyTwoStepsPerSecond, sixtyFourStepsPerSecond;
    logic [3:0]  modeMask;
    logic        hold, next;
    logic [1:0]  modeSel;
    logic [13:0] dispValue;
    logic [3:0]  dispDp;
    logic        dispBlank, modeChange;

    display_mode_scheduler #(.TICK_DIV(TD), .DWELL_SEC(DW), .BLANK_CYCLES(BC)) dut (
        .CLK(CLK), .RESET(RESET),
        .totalSteps(totalSteps), .distanceCovered(distanceCovered),
        .thirtyTwoStepsPerSecond(thirtyTwoStepsPerSecond),
        .sixtyFourStepsPerSecond(sixtyFourStepsPerSecond),
        .modeMask(modeMask), .hold(hold), .next(next),
        .modeSel(modeSel), .dispValue(dispValue), .dispDp(dispDp),
        .dispBlank(dispBlank), .modeChange(modeChange)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  sel;
        logic [13:0] val;
        logic [3:0]  dp;
        logic        mc;
    } vec_t;

    vec_t       tbl [NV];
    int         passed = 0;
    int         total = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Every modeChange pulse must match the next expected metric in the queue.
    always @(negedge CLK) begin
        if (RESET && modeChange) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_modeChange_sel", modeSel, 99);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_modeChange_sel", modeSel, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int blank_seen, sel_bad;
        totalSteps = 14'd1234;
        distanceCovered = 14'd567;
        thirtyTwoStepsPerSecond = 14'd89;
        sixtyFourStepsPerSecond = 14'd12000;
        modeMask = 4'b1111;
        hold = 1'b0;
        next = 1'b0;

        tbl[0]  = '{4'b1111, 2'd0, 14'd1234, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 2'd1, 14'd567,  4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 2'd2, 14'd89,   4'b0000, 1'b1};
        tbl[3]  = '{4'b1111, 2'd3, 14'd9999, 4'b0000, 1'b1};
        tbl[4]  = '{4'b1001, 2'd0, 14'd1234, 4'b0000, 1'b1};
        tbl[5]  = '{4'b1001, 2'd3, 14'd9999, 4'b0000, 1'b1};
        tbl[6]  = '{4'b1001, 2'd0, 14'd1234, 4'b0000, 1'b1};
        tbl[7]  = '{4'b1001, 2'd3, 14'd9999, 4'b0000, 1'b1};
        tbl[8]  = '{4'b0000, 2'd0, 14'd1234, 4'b0000, 1'b1};
        tbl[9]  = '{4'b0000, 2'd0, 14'd1234, 4'b0000, 1'b1};
        tbl[10] = '{4'b1111, 2'd0, 14'd1234, 4'b0000, 1'b1};

        step(2);
        chk("reset_dispValue", dispValue, 0);
        chk("reset_modeSel", modeSel, 0);
        RESET = 1'b1;   // cycle 0
        chk("rst_rel_dispValue", dispValue, 0);
        chk("rst_rel_blank", dispBlank, 0);
        chk("rst_rel_modeChange", modeChange, 0);
        chk("rst_rel_dp", dispDp, 0);

        // Each record is one metric period of 11 cycles starting at SHOW entry p.
        for (int i = 0; i < NV; i++) begin
            chk("tbl_sel", modeSel, tbl[i].sel);
            chk("tbl_modeChange", modeChange, tbl[i].mc);
            chk("tbl_dp", dispDp, tbl[i].dp);
            chk("tbl_blank_p0", dispBlank, 0);
            modeMask = tbl[i].mask;
            step(1);
            chk("tbl_value", dispValue, tbl[i].val);
            if (i < NV - 1) exp_q.push_back(tbl[i + 1].sel);
            step(6);
            chk("tbl_blank_p7", dispBlank, 0);
            step(1);
            chk("tbl_blank_p8", dispBlank, 1);
            step(2);
            chk("tbl_blank_p10", dispBlank, 1);
            if (i < NV - 1) step(1);
        end

        // Hold: 20 cycles of hold on metric 0, then the remaining dwell.
        RESET = 1'b0;
        modeMask = 4'b1111;
        step(2);
        RESET = 1'b1;
        step(1);
        hold = 1'b1;
        blank_seen = 0;
        sel_bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (dispBlank) blank_seen++;
            if (modeSel != 2'd0) sel_bad++;
        end
        hold = 1'b0;    // cycle 21
        chk("hold_no_blank", blank_seen, 0);
        chk("hold_sel_stays", sel_bad, 0);
        step(6);
        chk("hold_rel_blank_c27", dispBlank, 0);
        exp_q.push_back(2'd1);
        step(1);
        chk("hold_rel_blank_c28", dispBlank, 1);
        step(3);
        chk("hold_then_sel", modeSel, 1);
        chk("hold_then_mc", modeChange, 1);

        // Next at SHOW entry + 2, a second next during BLANK is ignored.
        step(2);
        next = 1'b1;
        step(1);
        next = 1'b0;
        chk("next_blank", dispBlank, 1);
        exp_q.push_back(2'd2);
        step(1);
        next = 1'b1;
        step(1);
        next = 1'b0;
        chk("next_blank_3rd", dispBlank, 1);
        step(1);
        chk("next_show", dispBlank, 0);
        chk("next_sel", modeSel, 2);
        chk("next_mc", modeChange, 1);
        step(1);
        chk("next_no_double_sel", modeSel, 2);
        chk("next_mc_pulse", modeChange, 0);
        step(6);
        chk("next_dwell_c7", dispBlank, 0);
        exp_q.push_back(2'd3);
        step(1);
        chk("next_dwell_c8", dispBlank, 1);

        // Clearing the mask bit of the shown metric forces an immediate change.
        step(3);
        chk("mask_sel3", modeSel, 3);
        chk("mask_sel3_mc", modeChange, 1);
        step(1);
        chk("sat_value", dispValue, 9999);
        modeMask = 4'b0111;
        exp_q.push_back(2'd0);
        step(1);
        chk("mask_clear_blank", dispBlank, 1);
        step(3);
        chk("mask_clear_show", dispBlank, 0);
        chk("mask_clear_sel", modeSel, 0);
        chk("mask_clear_mc", modeChange, 1);

        // Reach metric 1, then reset asynchronously in its second BLANK cycle.
        modeMask = 4'b1111;
        next = 1'b1;
        exp_q.push_back(2'd1);
        step(1);
        next = 1'b0;
        step(3);
        chk("pre_rst_sel", modeSel, 1);
        step(8);
        chk("pre_rst_blank", dispBlank, 1);
        step(1);
        #1 RESET = 1'b0;
        #1;
        chk("async_rst_blank", dispBlank, 0);
        chk("async_rst_sel", modeSel, 0);
        chk("async_rst_value", dispValue, 0);
        chk("async_rst_dp", dispDp, 0);
        chk("async_rst_mc", modeChange, 0);
        step(2);
        RESET = 1'b1;
        step(1);
        chk("post_rst_value", dispValue, 1234);
        step(6);
        chk("post_rst_dwell_c7", dispBlank, 0);
        step(1);
        chk("post_rst_dwell_c8", dispBlank, 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/display_mode_scheduler.md
Name: display_mode_scheduler

Overview:
- Controller that sequences the seven-segment output selector through the four fitness metrics: total steps, distance covered, seconds above 32 steps/s, and seconds above 64 steps/s.
- Rotates the displayed metric every DWELL_SEC seconds, inserts a short blank between metrics, and honours hold, next-button and per-metric enable mask.
- Drives the selected metric value, already saturated, into the digit-multiplexing output stage.

Parameters:
TICK_DIV, 100000000, CLK cycles per one-second tick (min 2)
DWELL_SEC, 2, seconds each metric stays on display (min 1)
BLANK_CYCLES, 1000000, CLK cycles the display is blanked between metrics (min 1)

Ports:
CLK  input  1  system clock, 100 MHz
RESET  input  1  asynchronous, active-low reset
totalSteps  input  14  step count
distanceCovered  input  14  distance in tenths of a mile
thirtyTwoStepsPerSecond  input  14  seconds spent above 32 steps/s
sixtyFourStepsPerSecond  input  14  seconds spent above 64 steps/s
modeMask  input  4  bit i = 1 enables metric i in the rotation
hold  input  1  level; freezes the dwell timer in SHOW
next  input  1  synchronous single-cycle pulse; skip to the next metric now
modeSel  output  2  metric being shown (0..3)
dispValue  output  14  value to display, saturated to 9999
dispDp  output  4  decimal-point enables, one per digit
dispBlank  output  1  1 = all anodes off
modeChange  output  1  1-cycle pulse on entering SHOW with a new metric

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-low.
- Reset values (RESET = 0):
  - state = SHOW, modeSel = 0, prescaler = 0, secCnt = 0.
  - dispValue = 0, dispDp = 0, dispBlank = 0, modeChange = 0.
- State SHOW:
  - dispValue is registered from the input selected by modeSel, 1-cycle latency, updated every cycle.
  - Any input > 9999 is output as 9999.
  - dispDp = 4'b0010 when modeSel = 1, else 0. dispBlank = 0.
  - prescaler counts 0..TICK_DIV-1 and wraps. The tick fires in the cycle prescaler = TICK_DIV-1.
  - On a tick with hold = 0, secCnt increments. With hold = 1, secCnt is frozen while the prescaler keeps running.
  - A tick with hold = 0 and secCnt = DWELL_SEC-1 moves the state to BLANK.
- Other SHOW exits:
  - next = 1 moves the state to BLANK next cycle, regardless of hold or timer.
  - modeMask[modeSel] = 0 while any mask bit is set moves the state to BLANK next cycle.
  - A simultaneous tick-expiry and next count as one transition only; no metric is skipped.
- Entering BLANK: prescaler and secCnt clear to 0 and are held during BLANK.
- State BLANK:
  - dispBlank = 1 and dispValue holds its last value.
  - blankCnt counts BLANK_CYCLES cycles, then the state returns to SHOW.
  - next, hold and mask changes during BLANK are ignored.
- Leaving BLANK (next-metric selection):
  - modeSel becomes the first enabled index among modeSel+1, +2, +3 (mod 4), then modeSel itself.
  - If modeMask = 0, modeSel = 0.
  - modeChange = 1 for the first SHOW cycle, even if modeSel is unchanged.
- modeMask = 0 in SHOW: metric 0 is shown and the timer rotation continues, re-selecting metric 0.
- Reset mid-operation: immediate return to reset values. The first dwell after reset release lasts the full DWELL_SEC*TICK_DIV cycles.
- Cycle timing: the dwell is exactly DWELL_SEC*TICK_DIV SHOW cycles, measured from SHOW entry to the first BLANK cycle, with hold = 0. A full metric period is DWELL_SEC*TICK_DIV + BLANK_CYCLES.

Test Plan:
All scenarios use TICK_DIV=4, DWELL_SEC=2, BLANK_CYCLES=3, modeMask=4'b1111, totalSteps=1234, distanceCovered=567, thirtyTwoStepsPerSecond=89, sixtyFourStepsPerSecond=12000.
- Rotation: release RESET -> modeSel=0, dispValue=1234 after 1 cycle. dispBlank=1 from cycle 8 to cycle 10. modeSel=1 with modeChange pulse at cycle 11, dispValue=567, dispDp=0010. Next metric period 11 cycles later: modeSel=2, dispValue=89. Then modeSel=3, dispValue=9999 (saturation), then wrap to 0.
- Hold: hold=1 for 20 cycles during modeSel=0 -> no BLANK and modeSel stays 0. After release, BLANK follows within the remaining dwell cycles.
- Next: next pulse at cycle 2 after SHOW entry -> dispBlank=1 next cycle for 3 cycles, then modeSel=1. next during BLANK -> ignored, no double advance.
- Mask skip: modeMask=4'b1001 -> sequence 0,3,0,3. Clearing bit 3 while modeSel=3 -> BLANK next cycle, then modeSel=0. modeMask=0 -> modeSel stays 0, modeChange still pulses every 11 cycles.
- Reset mid-BLANK: assert RESET during BLANK cycle 2 -> outputs at reset values immediately, with no CLK edge needed. After release, full 8-cycle dwell on modeSel=0.
